muldiv_issue_scheduler: RTL and testbench

Issue scheduler for the shared long-latency math units in the out-of-order core. Up to NUM_REQ reservation-station slots request the fully pipelined multiplier (whichMath=2) or the iterative divider (whichMath=3). The block grants one request per cycle by round-robin, tracks in-flight ops, and drives the single mult/div writeback slot on the CDB. It guarantees that mult and div never complete in the same cycle.

---
 rtl/muldiv_issue_scheduler_pkg.sv | 30 +++
 rtl/muldiv_issue_scheduler_rr_arbiter.sv | 33 +++
 rtl/muldiv_issue_scheduler.sv | 258 +++++++++++++++++++++++++
 tb/tb_muldiv_issue_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_issue_scheduler_pkg.sv
// Shared definitions for the mult/div issue scheduler: decoder whichMath
// encoding, divider FSM states and the in-flight tracking entry.
package muldiv_pkg;

    // Decoder whichMath encoding; only MULT and DIV are handled here.
    localparam logic [1:0] WM_ALU   = 2'd0;
    localparam logic [1:0] WM_SHIFT = 2'd1;
    localparam logic [1:0] WM_MULT  = 2'd2;
    localparam logic [1:0] WM_DIV   = 2'd3;

    // Widest destination tag an in-flight entry can carry. Narrower tags are
    // zero-extended on entry and truncated back on writeback.
    localparam int INFL_TAG_W = 16;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

    typedef struct packed {
        logic                  valid;
        logic [INFL_TAG_W-1:0] tag;
    } inflight_t;

    // True for op codes that go to the shared long-latency units.
    function automatic logic is_muldiv_op(input logic [1:0] wm);
        return (wm == WM_MULT) || (wm == WM_DIV);
    endfunction

endpackage

// File: rtl/muldiv_issue_scheduler_rr_arbiter.sv
// Round-robin arbiter: starting at ptr and wrapping, grants the first
// asserted request. Purely combinational; grant is one-hot or zero and idx is
// 0 when nothing is granted.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] k;

    // Scan from the pointer, wrapping, and keep the first hit.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            k = IDX_W'((int'(ptr) + i) % N);
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

endmodule

// File: rtl/muldiv_issue_scheduler.sv
// Issue scheduler for the shared pipelined multiplier and iterative divider.
// Grants one reservation-station request per cycle round-robin, tracks
// in-flight ops and drives the single mult/div CDB writeback slot, ensuring
// mult and div never write back in the same cycle.
// Optional build macro MULDIV_PERF_EN enables the performance counters;
// without it perf_mult_o/perf_div_o/perf_block_o are tied to zero.
//
// Handshake: slot i's request is accepted in a cycle where req_valid_i[i] and
// grant_o[i] are both high (grant acts as ready). Until then the slot holds
// valid, op and tag stable; on the cycle after acceptance it drops or
// replaces the request. Nothing is accepted while reset or flush_i is high.
module muldiv_issue_scheduler
    import muldiv_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int TAG_W    = 5,
    parameter int DATA_W   = 64,
    parameter int MULT_LAT = 3,
    parameter int DIV_LAT  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [2*NUM_REQ-1:0]         req_whichMath_i,
    input  logic [TAG_W*NUM_REQ-1:0]     req_tag_i,
    input  logic                         flush_i,
    input  logic [DATA_W-1:0]            mult_result_i,
    input  logic [DATA_W-1:0]            div_result_i,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic [$clog2(NUM_REQ)-1:0]   issue_sel_o,
    output logic                         mult_start_o,
    output logic                         div_start_o,
    output logic                         div_busy_o,
    output logic                         cdb_valid_o,
    output logic [TAG_W-1:0]             cdb_tag_o,
    output logic [DATA_W-1:0]            cdb_data_o,
    output logic [31:0]                  perf_mult_o,
    output logic [31:0]                  perf_div_o,
    output logic [31:0]                  perf_block_o
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int REM_W = $clog2(DIV_LAT);
    localparam logic [REM_W-1:0] REM_LOAD = REM_W'(DIV_LAT - 1);
    // A mult started while the divider has this many cycles left would land
    // on the divider's completion cycle.
    localparam logic [REM_W-1:0] REM_MULT = REM_W'(MULT_LAT);

    // Arbitration and start signals.
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_grant;
    logic [SEL_W-1:0]   arb_idx;
    logic [SEL_W-1:0]   ptr_q;
    logic               grant_any;
    logic [1:0]         granted_op;
    logic [TAG_W-1:0]   granted_tag;
    logic               mult_start;
    logic               div_start;
    logic               mult_ok;
    logic               div_ok;

    // Multiplier tracking pipe; index MULT_LAT-1 is the writeback stage.
    inflight_t          mult_pipe [MULT_LAT];

    // Divider FSM.
    div_state_t         div_state_q, div_state_n;
    logic [REM_W-1:0]   remain_q, remain_n;
    logic [TAG_W-1:0]   div_tag_q, div_tag_n;
    logic               div_done;

    // Writeback-collision and divider-occupancy gating.
    always_comb begin
        mult_ok = !((div_state_q == DIV_BUSY) && (remain_q == REM_MULT));
        div_ok  = (div_state_q == DIV_IDLE) || (remain_q == '0);
    end

    // Per-slot eligibility; ALU/shift ops are never granted here.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid_i[i] && is_muldiv_op(req_whichMath_i[2*i +: 2])) begin
                if (req_whichMath_i[2*i +: 2] == WM_MULT) begin
                    eligible[i] = mult_ok;
                end else begin
                    eligible[i] = div_ok;
                end
            end
        end
    end

    assign arb_req = (reset || flush_i) ? '0 : eligible;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (SEL_W)
    ) u_rr_arbiter (
        .req   (arb_req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Decode the granted slot's op and tag.
    always_comb begin
        grant_any   = |arb_grant;
        granted_op  = req_whichMath_i[2*arb_idx +: 2];
        granted_tag = req_tag_i[TAG_W*arb_idx +: TAG_W];
        mult_start  = grant_any && (granted_op == WM_MULT);
        div_start   = grant_any && (granted_op == WM_DIV);
    end

    assign grant_o      = arb_grant;
    assign issue_sel_o  = arb_idx;
    assign mult_start_o = mult_start;
    assign div_start_o  = div_start;
    assign div_busy_o   = !reset && (div_state_q == DIV_BUSY);

    // Round-robin pointer moves past the winner only when something is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (grant_any) begin
            ptr_q <= (arb_idx == SEL_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
    end

    // Multiplier in-flight shift register; flush kills every in-flight op.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                mult_pipe[i] <= '0;
            end
        end else begin
            mult_pipe[0].valid <= mult_start;
            mult_pipe[0].tag   <= INFL_TAG_W'(granted_tag);
            for (int i = 1; i < MULT_LAT; i++) begin
                mult_pipe[i] <= mult_pipe[i-1];
            end
        end
    end

    // Divider FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_state_q <= DIV_IDLE;
            remain_q    <= '0;
            div_tag_q   <= '0;
        end else begin
            div_state_q <= div_state_n;
            remain_q    <= remain_n;
            div_tag_q   <= div_tag_n;
        end
    end

    // Divider FSM next state: count down, complete at zero, reload on a
    // back-to-back start.
    always_comb begin
        div_state_n = div_state_q;
        remain_n    = remain_q;
        div_tag_n   = div_tag_q;
        if (flush_i) begin
            div_state_n = DIV_IDLE;
            remain_n    = '0;
        end else begin
            case (div_state_q)
                DIV_IDLE: begin
                    if (div_start) begin
                        div_state_n = DIV_BUSY;
                        remain_n    = REM_LOAD;
                        div_tag_n   = granted_tag;
                    end
                end
                DIV_BUSY: begin
                    if (remain_q == '0) begin
                        if (div_start) begin
                            remain_n  = REM_LOAD;
                            div_tag_n = granted_tag;
                        end else begin
                            div_state_n = DIV_IDLE;
                        end
                    end else begin
                        remain_n = remain_q - 1'b1;
                    end
                end
                default: begin
                    div_state_n = DIV_IDLE;
                    remain_n    = '0;
                end
            endcase
        end
    end

    assign div_done = (div_state_q == DIV_BUSY) && (remain_q == '0);

    // CDB writeback mux; the issue rules keep the two sources exclusive.
    always_comb begin
        cdb_valid_o = 1'b0;
        cdb_tag_o   = '0;
        cdb_data_o  = '0;
        if (!reset && !flush_i) begin
            if (mult_pipe[MULT_LAT-1].valid) begin
                cdb_valid_o = 1'b1;
                cdb_tag_o   = TAG_W'(mult_pipe[MULT_LAT-1].tag);
                cdb_data_o  = mult_result_i;
            end else if (div_done) begin
                cdb_valid_o = 1'b1;
                cdb_tag_o   = div_tag_q;
                cdb_data_o  = div_result_i;
            end
        end
    end

`ifdef MULDIV_PERF_EN
    logic        mult_req_any;
    logic [31:0] perf_mult_q;
    logic [31:0] perf_div_q;
    logic [31:0] perf_block_q;

    // Any slot currently asking for the multiplier.
    always_comb begin
        mult_req_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid_i[i] && (req_whichMath_i[2*i +: 2] == WM_MULT)) begin
                mult_req_any = 1'b1;
            end
        end
    end

    // Wrapping event counters; survive flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_mult_q  <= '0;
            perf_div_q   <= '0;
            perf_block_q <= '0;
        end else begin
            if (mult_start) begin
                perf_mult_q <= perf_mult_q + 32'd1;
            end
            if (div_start) begin
                perf_div_q <= perf_div_q + 32'd1;
            end
            if (mult_req_any && !mult_ok) begin
                perf_block_q <= perf_block_q + 32'd1;
            end
        end
    end

    assign perf_mult_o  = reset ? '0 : perf_mult_q;
    assign perf_div_o   = reset ? '0 : perf_div_q;
    assign perf_block_o = reset ? '0 : perf_block_q;
`else
    assign perf_mult_o  = '0;
    assign perf_div_o   = '0;
    assign perf_block_o = '0;
`endif

endmodule

// File: tb/tb_muldiv_issue_scheduler.sv
// Directed bench for muldiv_issue_scheduler. Inputs change 1 time unit after
// the rising edge; outputs are checked 4 units after it.
module tb_muldiv_issue_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int TAG_W    = 5;
  localparam int DATA_W   = 64;
  localparam logic [1:0] OP_ALU   = 2'd0;
  localparam logic [1:0] OP_SHIFT = 2'd1;
  localparam logic [1:0] OP_MUL   = 2'd2;
  localparam logic [1:0] OP_DIV   = 2'd3;
  localparam logic [63:0] MR = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DR = 64'hDEAD_BEEF_0000_0009;
`ifdef MULDIV_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                       clk;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [2*NUM_REQ-1:0]       req_wm;
  logic [TAG_W*NUM_REQ-1:0]   req_tag;
  logic                       flush;
  logic [DATA_W-1:0]          mult_result;
  logic [DATA_W-1:0]          div_result;
  logic [NUM_REQ-1:0]         grant;
  logic [1:0]                 issue_sel;
  logic                       mult_start;
  logic                       div_start;
  logic                       div_busy;
  logic                       cdb_valid;
  logic [TAG_W-1:0]           cdb_tag;
  logic [DATA_W-1:0]          cdb_data;
  logic [31:0]                perf_mult;
  logic [31:0]                perf_div;
  logic [31:0]                perf_block;

  int checks   = 0;
  int failures = 0;
  logic [TAG_W-1:0] exp_q[$];

  muldiv_issue_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid_i     (req_valid),
    .req_whichMath_i (req_wm),
    .req_tag_i       (req_tag),
    .flush_i         (flush),
    .mult_result_i   (mult_result),
    .div_result_i    (div_result),
    .grant_o         (grant),
    .issue_sel_o     (issue_sel),
    .mult_start_o    (mult_start),
    .div_start_o     (div_start),
    .div_busy_o      (div_busy),
    .cdb_valid_o     (cdb_valid),
    .cdb_tag_o       (cdb_tag),
    .cdb_data_o      (cdb_data),
    .perf_mult_o     (perf_mult),
    .perf_div_o      (perf_div),
    .perf_block_o    (perf_block)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard compare
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cdb_pop(input string tag, input logic [63:0] data);
    logic [TAG_W-1:0] t;
    t = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, "_valid"}, 64'(cdb_valid), 64'd1);
    chk({tag, "_tag"}, 64'(cdb_tag), 64'(t));
    chk({tag, "_data"}, cdb_data, data);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_sel"}, 64'(issue_sel), 64'd0);
    chk({tag, "_mstart"}, 64'(mult_start), 64'd0);
    chk({tag, "_dstart"}, 64'(div_start), 64'd0);
    chk({tag, "_busy"}, 64'(div_busy), 64'd0);
    chk({tag, "_cvalid"}, 64'(cdb_valid), 64'd0);
    chk({tag, "_ctag"}, 64'(cdb_tag), 64'd0);
    chk({tag, "_cdata"}, cdb_data, 64'd0);
    chk({tag, "_pmul"}, 64'(perf_mult), 64'd0);
    chk({tag, "_pdiv"}, 64'(perf_div), 64'd0);
    chk({tag, "_pblk"}, 64'(perf_block), 64'd0);
  endtask

  // drivers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_slot(input int s, input logic v, input logic [1:0] op, input logic [TAG_W-1:0] t);
    req_valid[s]             = v;
    req_wm[2*s +: 2]         = op;
    req_tag[TAG_W*s +: TAG_W] = t;
  endtask

  task automatic clear_slots();
    req_valid = '0;
    req_wm    = '0;
    req_tag   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    clear_slots();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    mult_result = MR;
    div_result  = DR;
    clear_slots();

    // Reset held two cycles with every slot requesting a mult.
    set_slot(0, 1'b1, OP_MUL, 5'd5);
    set_slot(1, 1'b1, OP_MUL, 5'd1);
    set_slot(2, 1'b1, OP_MUL, 5'd2);
    set_slot(3, 1'b1, OP_MUL, 5'd3);
    cyc();
    settle();
    chk_quiet("rst1");
    cyc();
    settle();
    chk_quiet("rst2");
    cyc();

    // Single mult, tag 5: grant at 0, writeback at 3.
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) clear_slots();
      settle();
      if (c == 0) begin
        chk("m1_grant", 64'(grant), 64'b0001);
        chk("m1_sel", 64'(issue_sel), 64'd0);
        chk("m1_mstart", 64'(mult_start), 64'd1);
        chk("m1_dstart", 64'(div_start), 64'd0);
        exp_q.push_back(5'd5);
      end
      if (c == 1 || c == 2 || c == 4) chk("m1_cdb_idle", 64'(cdb_valid), 64'd0);
      if (c == 3) chk_cdb_pop("m1_cdb", MR);
      cyc();
    end

    // Three mults from slots 0..2 held until granted.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        set_slot(0, 1'b1, OP_MUL, 5'd10);
        set_slot(1, 1'b1, OP_MUL, 5'd11);
        set_slot(2, 1'b1, OP_MUL, 5'd12);
      end
      if (c >= 1 && c <= 3) set_slot(c - 1, 1'b0, OP_ALU, 5'd0);
      settle();
      if (c <= 2) begin
        chk("rr_grant", 64'(grant), 64'(4'b0001 << c));
        chk("rr_sel", 64'(issue_sel), 64'(c));
        exp_q.push_back(TAG_W'(10 + c));
      end
      if (c >= 3 && c <= 5) chk_cdb_pop("rr_cdb", MR);
      if (c == 6) chk("rr_cdb_idle", 64'(cdb_valid), 64'd0);
      cyc();
    end

    // Div tag 9, blocked mult tag 7, back-to-back div tag 20.
    do_reset();
    for (int c = 0; c < 34; c++) begin
      if (c == 0) set_slot(0, 1'b1, OP_DIV, 5'd9);
      if (c == 1) begin
        set_slot(0, 1'b0, OP_ALU, 5'd0);
        set_slot(2, 1'b1, OP_DIV, 5'd20);
      end
      if (c == 13) set_slot(1, 1'b1, OP_MUL, 5'd7);
      if (c == 15) set_slot(1, 1'b0, OP_ALU, 5'd0);
      if (c == 17) set_slot(2, 1'b0, OP_ALU, 5'd0);
      settle();
      if (c == 0) begin
        chk("d_grant0", 64'(grant), 64'b0001);
        chk("d_dstart0", 64'(div_start), 64'd1);
        chk("d_mstart0", 64'(mult_start), 64'd0);
      end
      if (c >= 1 && c <= 13) begin
        chk("d_nogrant", 64'(grant), 64'd0);
        chk("d_busy", 64'(div_busy), 64'd1);
      end
      if (c == 14) begin
        chk("d_mgrant", 64'(grant), 64'b0010);
        chk("d_msel", 64'(issue_sel), 64'd1);
        chk("d_mstart", 64'(mult_start), 64'd1);
        chk("d_pblk", 64'(perf_block), PERF ? 64'd1 : 64'd0);
      end
      if (c == 15) begin
        chk("d_grant15", 64'(grant), 64'd0);
        chk("d_cdb15", 64'(cdb_valid), 64'd0);
      end
      if (c == 16) begin
        exp_q.push_back(5'd9);
        chk_cdb_pop("d_cdb16", DR);
        chk("d_grant16", 64'(grant), 64'b0100);
        chk("d_sel16", 64'(issue_sel), 64'd2);
        chk("d_dstart16", 64'(div_start), 64'd1);
        exp_q.push_back(5'd7);
      end
      if (c == 17) begin
        chk_cdb_pop("d_cdb17", MR);
        chk("d_busy17", 64'(div_busy), 64'd1);
        chk("d_pmul", 64'(perf_mult), PERF ? 64'd1 : 64'd0);
        chk("d_pdiv", 64'(perf_div), PERF ? 64'd2 : 64'd0);
        chk("d_pblk17", 64'(perf_block), PERF ? 64'd1 : 64'd0);
        exp_q.push_back(5'd20);
      end
      if (c == 31) chk("d_cdb31", 64'(cdb_valid), 64'd0);
      if (c == 32) chk_cdb_pop("d_cdb32", DR);
      if (c == 33) begin
        chk("d_busy33", 64'(div_busy), 64'd0);
        chk("d_cdb33", 64'(cdb_valid), 64'd0);
      end
      cyc();
    end

    // Flush kills mult at 0 and div at 1; non-muldiv ops never granted.
    do_reset();
    for (int c = 0; c < 21; c++) begin
      if (c == 0) begin
        set_slot(0, 1'b1, OP_MUL, 5'd3);
        set_slot(3, 1'b1, OP_ALU, 5'd1);
      end
      if (c == 1) begin
        set_slot(0, 1'b1, OP_SHIFT, 5'd2);
        set_slot(1, 1'b1, OP_DIV, 5'd4);
      end
      if (c == 2) begin
        set_slot(1, 1'b0, OP_ALU, 5'd0);
        set_slot(2, 1'b1, OP_DIV, 5'd6);
        flush = 1'b1;
      end
      if (c == 3) flush = 1'b0;
      if (c == 4) set_slot(2, 1'b0, OP_ALU, 5'd0);
      settle();
      if (c == 0) begin
        chk("f_grant0", 64'(grant), 64'b0001);
        chk("f_mstart0", 64'(mult_start), 64'd1);
      end
      if (c == 1) begin
        chk("f_grant1", 64'(grant), 64'b0010);
        chk("f_sel1", 64'(issue_sel), 64'd1);
        chk("f_dstart1", 64'(div_start), 64'd1);
      end
      if (c == 2) begin
        chk("f_grant2", 64'(grant), 64'd0);
        chk("f_dstart2", 64'(div_start), 64'd0);
        chk("f_cdb2", 64'(cdb_valid), 64'd0);
      end
      if (c == 3) begin
        chk("f_busy3", 64'(div_busy), 64'd0);
        chk("f_cdb3", 64'(cdb_valid), 64'd0);
        chk("f_grant3", 64'(grant), 64'b0100);
        chk("f_sel3", 64'(issue_sel), 64'd2);
        chk("f_dstart3", 64'(div_start), 64'd1);
        exp_q.push_back(5'd6);
      end
      if (c >= 4 && c <= 18) begin
        chk("f_nogrant", 64'(grant), 64'd0);
        chk("f_cdb_idle", 64'(cdb_valid), 64'd0);
      end
      if (c == 19) chk_cdb_pop("f_cdb19", DR);
      if (c == 20) begin
        chk("f_pmul", 64'(perf_mult), PERF ? 64'd1 : 64'd0);
        chk("f_pdiv", 64'(perf_div), PERF ? 64'd2 : 64'd0);
        chk("f_pblk", 64'(perf_block), 64'd0);
      end
      cyc();
    end

    // Reset in the middle of a divide clears FSM, pointer and counters.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      if (c == 0) set_slot(0, 1'b1, OP_DIV, 5'd8);
      if (c == 1) set_slot(0, 1'b0, OP_ALU, 5'd0);
      if (c == 2) begin
        reset = 1'b1;
        set_slot(1, 1'b1, OP_MUL, 5'd12);
      end
      if (c == 3) begin
        reset = 1'b0;
        set_slot(0, 1'b1, OP_MUL, 5'd11);
      end
      if (c == 4) set_slot(0, 1'b0, OP_ALU, 5'd0);
      if (c == 5) set_slot(1, 1'b0, OP_ALU, 5'd0);
      settle();
      if (c == 0) chk("r_dstart0", 64'(div_start), 64'd1);
      if (c == 1) chk("r_busy1", 64'(div_busy), 64'd1);
      if (c == 2) chk_quiet("r_mid");
      if (c == 3) begin
        chk("r_busy3", 64'(div_busy), 64'd0);
        chk("r_grant3", 64'(grant), 64'b0001);
        chk("r_pdiv3", 64'(perf_div), 64'd0);
        exp_q.push_back(5'd11);
      end
      if (c == 4) begin
        chk("r_grant4", 64'(grant), 64'b0010);
        chk("r_pmul4", 64'(perf_mult), PERF ? 64'd1 : 64'd0);
        exp_q.push_back(5'd12);
      end
      if (c == 6) chk_cdb_pop("r_cdb6", MR);
      if (c == 7) chk_cdb_pop("r_cdb7", MR);
      if (c == 16) chk("r_cdb16", 64'(cdb_valid), 64'd0);
      cyc();
    end

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
